// File: rtl/ocx_tlx_rcv_pkg.sv
// Shared types for the TLX receive-side command path.
package ocx_tlx_rcv_pkg;

    localparam int INFO_W = 168;

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    typedef logic [INFO_W-1:0] cmd_info_t;

endpackage

// File: rtl/ocx_tlx_sync_fifo_mem.sv
// Storage array for the receive command FIFO: one write port, one asynchronous read port.
module ocx_tlx_sync_fifo_mem
    import ocx_tlx_rcv_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = INFO_W,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Data carries no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/ocx_tlx_rcv_cmd_queue.sv
// Receive-side VC1 command queue: buffers parsed commands and issues them to the AFU
// under AFU credit, returning one VC1 credit to the transmitter per issued command.
module ocx_tlx_rcv_cmd_queue #(
    parameter int DEPTH  = 16,
    parameter int INFO_W = ocx_tlx_rcv_pkg::INFO_W,
    parameter int CRED_W = 7,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              tlx_clk,
    input  logic              reset_n,
    input  logic              fp_rcv_cmd_valid,
    input  logic [INFO_W-1:0] fp_rcv_cmd_info,
    input  logic [CRED_W-1:0] afu_tlx_cmd_initial_credit,
    input  logic              afu_tlx_cmd_credit,
    output logic              tlx_afu_cmd_valid,
    output logic [INFO_W-1:0] tlx_afu_cmd_info,
    output logic              rcv_xmt_vc1_credit_v,
    output logic [AW:0]       cmd_fifo_count,
    output logic              cmd_fifo_overflow,
    output logic              cmd_credit_err
);

    import ocx_tlx_rcv_pkg::*;

    state_e state_q, state_d;

    logic [AW:0]       wptr_q, wptr_d;
    logic [AW:0]       rptr_q, rptr_d;
    logic [AW:0]       count_q, count_d;
    logic [CRED_W-1:0] afu_cred_q, afu_cred_d;
    logic [CRED_W-1:0] cred_max_q, cred_max_d;
    logic [INFO_W-1:0] info_q, info_d;
    logic              valid_q;
    logic              overflow_q, overflow_d;
    logic              cred_err_q, cred_err_d;

    logic              full;
    logic              empty;
    logic              pop;
    logic              push_ok;
    logic [CRED_W:0]   cred_sum;
    logic              cred_over;
    logic [INFO_W-1:0] rd_data;

    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty   = (wptr_q == rptr_q);
    assign pop     = (state_q == RUN) && !empty && (afu_cred_q != '0);
    // A pop frees a slot in the same cycle, so a full queue can still accept a push.
    assign push_ok = fp_rcv_cmd_valid && (!full || pop);

    assign cred_sum  = {1'b0, afu_cred_q} - (CRED_W+1)'(pop) + (CRED_W+1)'(afu_tlx_cmd_credit);
    assign cred_over = (cred_sum > {1'b0, cred_max_q});

    ocx_tlx_sync_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (INFO_W)
    ) u_mem (
        .clk   (tlx_clk),
        .we    (push_ok),
        .waddr (wptr_q[AW-1:0]),
        .wdata (fp_rcv_cmd_info),
        .raddr (rptr_q[AW-1:0]),
        .rdata (rd_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        wptr_d     = wptr_q + (AW+1)'(push_ok);
        rptr_d     = rptr_q + (AW+1)'(pop);
        count_d    = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
        info_d     = pop ? rd_data : info_q;
        overflow_d = overflow_q | (fp_rcv_cmd_valid & ~push_ok);
        afu_cred_d = afu_cred_q;
        cred_max_d = cred_max_q;
        cred_err_d = cred_err_q;
        if (state_q == INIT) begin
            afu_cred_d = afu_tlx_cmd_initial_credit;
            cred_max_d = afu_tlx_cmd_initial_credit;
        end else if (cred_over) begin
            // An excess credit return is discarded; only the pop is accounted.
            afu_cred_d = afu_cred_q - CRED_W'(pop);
            cred_err_d = 1'b1;
        end else begin
            afu_cred_d = cred_sum[CRED_W-1:0];
        end
    end

    always_ff @(posedge tlx_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= INIT;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            afu_cred_q <= '0;
            cred_max_q <= '0;
            info_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            cred_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            afu_cred_q <= afu_cred_d;
            cred_max_q <= cred_max_d;
            info_q     <= info_d;
            valid_q    <= pop;
            overflow_q <= overflow_d;
            cred_err_q <= cred_err_d;
        end
    end

    assign tlx_afu_cmd_valid    = valid_q;
    assign rcv_xmt_vc1_credit_v = valid_q;
    assign tlx_afu_cmd_info     = info_q;
    assign cmd_fifo_count       = count_q;
    assign cmd_fifo_overflow    = overflow_q;
    assign cmd_credit_err       = cred_err_q;

endmodule

// File: tb/tb_ocx_tlx_rcv_cmd_queue.sv
// Directed self-checking bench for the receive command queue (DEPTH=16, INFO_W=168, CRED_W=7).
module tb_ocx_tlx_rcv_cmd_queue;

    logic         clk;
    logic         reset_n;
    logic         fpValid;
    logic [167:0] fpInfo;
    logic [6:0]   initCredit;
    logic         afuCredit;
    logic         cmdValid;
    logic [167:0] cmdInfo;
    logic         vc1CreditV;
    logic [4:0]   fifoCount;
    logic         fifoOverflow;
    logic         creditErr;

    int vectors     = 0;
    int miscompares = 0;

    ocx_tlx_rcv_cmd_queue dut (
        .tlx_clk                    (clk),
        .reset_n                    (reset_n),
        .fp_rcv_cmd_valid           (fpValid),
        .fp_rcv_cmd_info            (fpInfo),
        .afu_tlx_cmd_initial_credit (initCredit),
        .afu_tlx_cmd_credit         (afuCredit),
        .tlx_afu_cmd_valid          (cmdValid),
        .tlx_afu_cmd_info           (cmdInfo),
        .rcv_xmt_vc1_credit_v       (vc1CreditV),
        .cmd_fifo_count             (fifoCount),
        .cmd_fifo_overflow          (fifoOverflow),
        .cmd_credit_err             (creditErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and sample just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [167:0] info, input logic cred);
        fpValid   = v;
        fpInfo    = info;
        afuCredit = cred;
    endtask

    task automatic checkOutput(input string tag, input logic [167:0] observed, input logic [167:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_valid"}, cmdValid, 0);
        checkOutput({tag, "_vc1"}, vc1CreditV, 0);
        checkOutput({tag, "_count"}, fifoCount, 0);
        checkOutput({tag, "_ovf"}, fifoOverflow, 0);
        checkOutput({tag, "_err"}, creditErr, 0);
        checkOutput({tag, "_info"}, cmdInfo, 0);
    endtask

    // Reset with a given initial credit and step through the INIT cycle.
    task automatic resetDut(input logic [6:0] cred);
        applyStimulus(0, '0, 0);
        initCredit = cred;
        reset_n    = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(0, '0, 0);
        initCredit = 7'd4;
        reset_n    = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        checkAllZero("reset");
        tick();
        reset_n = 1'b1;
        tick();

        // Six back-to-back pushes with four credits: four issues, two left queued.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 168'(i + 1), 0);
            tick();
            checkOutput("t1_valid", cmdValid, (i >= 1 && i <= 4));
            checkOutput("t1_vc1", vc1CreditV, (i >= 1 && i <= 4));
            checkOutput("t1_count", fifoCount, (i < 5) ? 1 : 2);
            if (i >= 1 && i <= 4) checkOutput("t1_info", cmdInfo, i);
        end
        applyStimulus(0, '0, 0);
        tick();
        checkOutput("t1_idle_valid", cmdValid, 0);
        checkOutput("t1_idle_count", fifoCount, 2);

        // Two credit returns release the remaining two in push order.
        applyStimulus(0, '0, 1);
        tick();
        checkOutput("t2_c0_valid", cmdValid, 0);
        tick();
        checkOutput("t2_c1_valid", cmdValid, 1);
        checkOutput("t2_c1_info", cmdInfo, 5);
        applyStimulus(0, '0, 0);
        tick();
        checkOutput("t2_c2_valid", cmdValid, 1);
        checkOutput("t2_c2_info", cmdInfo, 6);
        checkOutput("t2_c2_count", fifoCount, 0);
        tick();
        checkOutput("t2_c3_valid", cmdValid, 0);
        checkOutput("t2_err", creditErr, 0);

        // Zero initial credit: fill to 16, the 17th push overflows.
        resetDut(7'd0);
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1, 168'(100 + i), 0);
            tick();
            if (i == 15) begin
                checkOutput("t3_full_count", fifoCount, 16);
                checkOutput("t3_full_ovf", fifoOverflow, 0);
            end
            if (i == 16) begin
                checkOutput("t3_ovf_count", fifoCount, 16);
                checkOutput("t3_ovf", fifoOverflow, 1);
            end
        end
        applyStimulus(0, '0, 0);
        tick();
        checkOutput("t3_valid", cmdValid, 0);
        checkOutput("t3_ovf_sticky", fifoOverflow, 1);
        checkOutput("t3_err", creditErr, 0);

        // Credit 1: one issue drains the credit, refill to full, then push+pop together.
        resetDut(7'd1);
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1, 168'(200 + i), 0);
            tick();
            if (i == 1) checkOutput("t4_first_info", cmdInfo, 200);
        end
        checkOutput("t4_full_count", fifoCount, 16);
        checkOutput("t4_full_ovf", fifoOverflow, 0);
        applyStimulus(0, '0, 1);
        tick();
        checkOutput("t4_cred_valid", cmdValid, 0);
        applyStimulus(1, 168'(300), 0);
        tick();
        checkOutput("t4_pp_valid", cmdValid, 1);
        checkOutput("t4_pp_info", cmdInfo, 201);
        checkOutput("t4_pp_count", fifoCount, 16);
        checkOutput("t4_pp_ovf", fifoOverflow, 0);
        applyStimulus(0, '0, 0);
        tick();
        checkOutput("t4_after_count", fifoCount, 16);

        // Credit returned beyond the initial count is flagged and ignored.
        resetDut(7'd2);
        applyStimulus(0, '0, 1);
        tick();
        checkOutput("t5_err", creditErr, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 168'(400 + i), 0);
            tick();
        end
        applyStimulus(0, '0, 0);
        tick();
        tick();
        checkOutput("t5_count", fifoCount, 1);
        checkOutput("t5_err_sticky", creditErr, 1);

        // Queue five entries, then assert reset between edges.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 168'(450 + i), 0);
            tick();
        end
        applyStimulus(0, '0, 0);
        checkOutput("t6_count5", fifoCount, 5);
        #2 reset_n = 1'b0;
        #1;
        checkAllZero("t6_async");
        initCredit = 7'd1;
        tick();
        reset_n = 1'b1;
        tick();
        checkOutput("t6_init_valid", cmdValid, 0);
        applyStimulus(1, 168'(500), 0);
        tick();
        checkOutput("t6_e0_valid", cmdValid, 0);
        checkOutput("t6_e0_count", fifoCount, 1);
        applyStimulus(0, '0, 0);
        tick();
        checkOutput("t6_e1_valid", cmdValid, 1);
        checkOutput("t6_e1_vc1", vc1CreditV, 1);
        checkOutput("t6_e1_info", cmdInfo, 500);
        checkOutput("t6_e1_count", fifoCount, 0);
        tick();
        checkOutput("t6_e2_valid", cmdValid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
